sram_bist_ctrl: RTL and testbench

- Built-in self-test initiator for the single-port `sram` block (wren/rden/addr/wr_data/rd_data interface).
- Drives the SRAM port through a March C- sequence, compares every read against the expected pattern, and reports pass/fail with first-failure capture.
- Sits between the SRAM and its functional master. The top-level mux selects this block while `busy`=1.

---
 rtl/sram_bist_ctrl.sv | 179 +++++++++++++++++
 tb/tb_sram_bist_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bist_ctrl.sv
// March C- built-in self-test initiator for a single-port SRAM.
// Issues one op per cycle, compares delayed read data and records the first failure.
module sram_bist_ctrl #(
   parameter int               WIDTH  = 32,
   parameter int               DEPTH  = 1024,
   parameter int               RD_LAT = 1,
   parameter logic [WIDTH-1:0] BG     = '0,
   localparam int              AW     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic [AW-1:0]    fail_addr,
   output logic [WIDTH-1:0] fail_data,
   output logic [15:0]      err_cnt,
   output logic             mem_wren,
   output logic             mem_rden,
   output logic [AW-1:0]    mem_addr,
   output logic [WIDTH-1:0] mem_wr_data,
   input  logic [WIDTH-1:0] mem_rd_data
);

   typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, M4, M5, DRAIN} state_t;

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t           state;
   state_t           nxt_state;
   logic             phase;
   logic             nxt_phase;
   logic [AW-1:0]    nxt_addr;
   logic             nxt_wr;
   logic             nxt_rd;
   logic [2:0]       drain_cnt;
   logic             cmp_err;
   logic             pipe_v    [RD_LAT];
   logic [AW-1:0]    pipe_addr [RD_LAT];
   logic [WIDTH-1:0] pipe_exp  [RD_LAT];

   function automatic logic is_down(state_t s);
      return s inside {M3, M4, M5};
   endfunction

   function automatic logic is_pair(state_t s);
      return s inside {M1, M2, M3, M4};
   endfunction

   function automatic logic is_read(state_t s);
      return s inside {M1, M2, M3, M4, M5};
   endfunction

   function automatic logic [WIDTH-1:0] rd_pat(state_t s);
      return (s inside {M2, M4}) ? ~BG : BG;
   endfunction

   function automatic logic [WIDTH-1:0] wr_pat(state_t s);
      return (s inside {M1, M3}) ? ~BG : BG;
   endfunction

   function automatic state_t succ(state_t s);
      case (s)
         M0:      return M1;
         M1:      return M2;
         M2:      return M3;
         M3:      return M4;
         M4:      return M5;
         M5:      return DRAIN;
         default: return s;
      endcase
   endfunction

   // Next op: read then write at one address, then step; terminal address hands over to the next element.
   always_comb begin
      nxt_state = state;
      nxt_phase = 1'b0;
      nxt_addr  = mem_addr;
      if (is_pair(state) && !phase) begin
         nxt_phase = 1'b1;
      end else if (mem_addr == (is_down(state) ? '0 : LAST)) begin
         nxt_state = succ(state);
         if (nxt_state != DRAIN)
            nxt_addr = is_down(nxt_state) ? LAST : '0;
      end else begin
         nxt_addr = is_down(state) ? mem_addr - AW'(1) : mem_addr + AW'(1);
      end
      nxt_wr = (nxt_state == M0) || nxt_phase;
      nxt_rd = is_read(nxt_state) && !nxt_phase;
   end

   assign cmp_err = pipe_v[RD_LAT-1] && (mem_rd_data != pipe_exp[RD_LAT-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         phase       <= 1'b0;
         drain_cnt   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         fail_addr   <= '0;
         fail_data   <= '0;
         err_cnt     <= '0;
         mem_wren    <= 1'b0;
         mem_rden    <= 1'b0;
         mem_addr    <= '0;
         mem_wr_data <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_v[i]    <= 1'b0;
            pipe_addr[i] <= '0;
            pipe_exp[i]  <= '0;
         end
      end else begin
         // state is aligned with the op on the port, so it names the expected read pattern
         pipe_v[0]    <= mem_rden;
         pipe_addr[0] <= mem_addr;
         pipe_exp[0]  <= rd_pat(state);
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i]    <= pipe_v[i-1];
            pipe_addr[i] <= pipe_addr[i-1];
            pipe_exp[i]  <= pipe_exp[i-1];
         end

         if (cmp_err) begin
            if (err_cnt != 16'hFFFF)
               err_cnt <= err_cnt + 16'd1;
            if (!fail) begin
               fail      <= 1'b1;
               fail_addr <= pipe_addr[RD_LAT-1];
               fail_data <= mem_rd_data;
            end
         end

         unique case (state)
            IDLE: begin
               if (start) begin
                  state       <= M0;
                  phase       <= 1'b0;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  pass        <= 1'b0;
                  fail        <= 1'b0;
                  fail_addr   <= '0;
                  fail_data   <= '0;
                  err_cnt     <= '0;
                  mem_wren    <= 1'b1;
                  mem_rden    <= 1'b0;
                  mem_addr    <= '0;
                  mem_wr_data <= BG;
               end
            end
            DRAIN: begin
               if (drain_cnt == 3'(RD_LAT - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_cnt == 16'd0) && !cmp_err;
               end else begin
                  drain_cnt <= drain_cnt + 3'd1;
               end
            end
            default: begin
               state       <= nxt_state;
               phase       <= nxt_phase;
               drain_cnt   <= '0;
               mem_addr    <= nxt_addr;
               mem_wren    <= nxt_wr;
               mem_rden    <= nxt_rd;
               mem_wr_data <= nxt_wr ? wr_pat(nxt_state) : '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Bench for sram_bist_ctrl: two instances (RD_LAT 1 and 3) on behavioural SRAMs with optional stuck-at cells,
// checked against a March C- reference built from the element list.
module tb_sram_bist_ctrl;

   localparam int          DEPTH = 16;
   localparam int          AW    = 4;
   localparam logic [31:0] BG    = 32'h0;
   localparam int          N_OPS = 10 * DEPTH;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } op_t;

   typedef struct {
      int            sel;
      logic          fen;
      int            faddr;
      int            fbit;
      logic          fval;
      int            mid;
      int            exp_err;
      logic [AW-1:0] exp_faddr;
      logic [31:0]   exp_fdata;
      logic          exp_pass;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start       [2];
   logic          busy        [2];
   logic          done        [2];
   logic          pass        [2];
   logic          fail        [2];
   logic [AW-1:0] fail_addr   [2];
   logic [31:0]   fail_data   [2];
   logic [15:0]   err_cnt     [2];
   logic          mem_wren    [2];
   logic          mem_rden    [2];
   logic [AW-1:0] mem_addr    [2];
   logic [31:0]   mem_wr_data [2];
   logic [31:0]   mem_rd_data [2];

   logic fault_en   [2];
   int   fault_addr [2];
   int   fault_bit  [2];
   logic fault_val  [2];

   int  n_cmp = 0;
   int  n_bad = 0;
   op_t exp_ops[$];

   always #5 clk = ~clk;

   function automatic int lat_of(input int s);
      return (s == 0) ? 1 : 3;
   endfunction

   function automatic logic [31:0] faulty(input int s, input int a, input logic [31:0] d);
      logic [31:0] m;
      m = 32'h1 << fault_bit[s];
      if (fault_en[s] && a == fault_addr[s])
         return fault_val[s] ? (d | m) : (d & ~m);
      return d;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int LAT = (g == 0) ? 1 : 3;
      logic [31:0] mem [DEPTH];
      logic [31:0] dl  [LAT];

      sram_bist_ctrl #(.WIDTH(32), .DEPTH(DEPTH), .RD_LAT(LAT), .BG(BG)) dut (
         .clk         (clk),
         .rst         (rst),
         .start       (start[g]),
         .busy        (busy[g]),
         .done        (done[g]),
         .pass        (pass[g]),
         .fail        (fail[g]),
         .fail_addr   (fail_addr[g]),
         .fail_data   (fail_data[g]),
         .err_cnt     (err_cnt[g]),
         .mem_wren    (mem_wren[g]),
         .mem_rden    (mem_rden[g]),
         .mem_addr    (mem_addr[g]),
         .mem_wr_data (mem_wr_data[g]),
         .mem_rd_data (mem_rd_data[g])
      );

      // Garbage on idle cycles so a misaligned compare cannot pass by luck
      always @(posedge clk) begin
         if (mem_wren[g])
            mem[mem_addr[g]] <= mem_wr_data[g];
         dl[0] <= mem_rden[g] ? faulty(g, int'(mem_addr[g]), mem[mem_addr[g]]) : $urandom;
         for (int i = 1; i < LAT; i++)
            dl[i] <= dl[i-1];
      end

      assign mem_rd_data[g] = dl[LAT-1];
   end

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: walk the six March C- elements, list every op and predict what a stuck-at cell returns.
   function automatic void build_model(input int s, output int e_err, output logic [AW-1:0] e_faddr,
                                       output logic [31:0] e_fdata);
      logic [31:0] rp, wp, got;
      int          a;
      op_t         op;
      exp_ops.delete();
      e_err   = 0;
      e_faddr = '0;
      e_fdata = '0;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < DEPTH; i++) begin
            a = (e >= 3) ? DEPTH - 1 - i : i;
            if (e != 0) begin
               rp      = (e == 2 || e == 4) ? ~BG : BG;
               op.wr   = 1'b0;
               op.addr = AW'(a);
               op.data = rp;
               exp_ops.push_back(op);
               got = faulty(s, a, rp);
               if (got != rp) begin
                  if (e_err == 0) begin
                     e_faddr = AW'(a);
                     e_fdata = got;
                  end
                  e_err++;
               end
            end
            if (e != 5) begin
               wp      = (e == 1 || e == 3) ? ~BG : BG;
               op.wr   = 1'b1;
               op.addr = AW'(a);
               op.data = wp;
               exp_ops.push_back(op);
            end
         end
      end
   endfunction

   task automatic apply_stimulus(input int s, input int mid_start, input int abort_at,
                                 output int r_err, output logic [AW-1:0] r_faddr,
                                 output logic [31:0] r_fdata, output logic r_pass);
      int            e_err;
      logic [AW-1:0] e_faddr;
      logic [31:0]   e_fdata;
      int            n, idx, op_err, busy_cnt, done_at, clash, late_done;
      logic [31:0]   want_wd;

      build_model(s, e_err, e_faddr, e_fdata);
      r_err   = -1;
      r_faddr = '0;
      r_fdata = '0;
      r_pass  = 1'b0;

      start[s] = 1'b1;
      @(negedge clk);
      start[s] = 1'b0;
      check_output("start_clear", {busy[s], done[s], fail[s], pass[s], err_cnt[s]},
                   {1'b1, 1'b0, 1'b0, 1'b0, 16'h0});

      n = 1; idx = 0; op_err = 0; busy_cnt = 0; done_at = 0; clash = 0;
      while (done_at == 0 && n <= N_OPS + 8) begin
         if (busy[s]) busy_cnt++;
         if (mem_wren[s] && mem_rden[s]) clash++;
         if (mem_wren[s] || mem_rden[s]) begin
            if (idx >= exp_ops.size()) begin
               op_err++;
            end else begin
               want_wd = exp_ops[idx].wr ? exp_ops[idx].data : 32'h0;
               if (mem_wren[s] !== exp_ops[idx].wr || mem_rden[s] !== !exp_ops[idx].wr ||
                   mem_addr[s] !== exp_ops[idx].addr || mem_wr_data[s] !== want_wd) begin
                  if (op_err == 0)
                     $display("[TB] op %0d differs at cycle %0d: wren=%b rden=%b addr=%0d data=%h",
                              idx, n, mem_wren[s], mem_rden[s], mem_addr[s], mem_wr_data[s]);
                  op_err++;
               end
            end
            idx++;
         end
         if (done[s]) done_at = n;
         if (abort_at == n) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_output("abort_idle", {mem_wren[s], mem_rden[s], busy[s], done[s]}, 4'b0);
            late_done = 0;
            repeat (2 * N_OPS) begin
               @(negedge clk);
               if (done[s] || busy[s]) late_done++;
            end
            check_output("abort_no_done", late_done, 0);
            return;
         end
         start[s] = (n == mid_start);
         @(negedge clk);
         n++;
      end
      start[s] = 1'b0;

      check_output("done_cycle",   done_at,   N_OPS + lat_of(s) + 1);
      check_output("busy_cycles",  busy_cnt,  N_OPS + lat_of(s));
      check_output("busy_at_done", busy[s],   1'b0);
      check_output("op_count",     idx,       N_OPS);
      check_output("op_sequence",  op_err,    0);
      check_output("rw_exclusive", clash,     0);
      check_output("err_cnt",      err_cnt[s],   e_err);
      check_output("pass",         pass[s],      e_err == 0);
      check_output("fail",         fail[s],      e_err != 0);
      check_output("fail_addr",    fail_addr[s], e_faddr);
      check_output("fail_data",    fail_data[s], e_fdata);

      r_err   = int'(err_cnt[s]);
      r_faddr = fail_addr[s];
      r_fdata = fail_data[s];
      r_pass  = pass[s];
   endtask

   initial begin
      vec_t          vecs[5];
      int            r_err;
      logic [AW-1:0] r_faddr;
      logic [31:0]   r_fdata;
      logic          r_pass;
      int            s;

      vecs[0] = '{0, 1'b0, 0, 0, 1'b0, 30, 0, 4'd0, 32'h0,         1'b1};
      vecs[1] = '{0, 1'b1, 5, 0, 1'b1, 0,  3, 4'd5, 32'h0000_0001, 1'b0};
      vecs[2] = '{0, 1'b1, 5, 0, 1'b1, 77, 3, 4'd5, 32'h0000_0001, 1'b0};
      vecs[3] = '{1, 1'b0, 0, 0, 1'b0, 0,  0, 4'd0, 32'h0,         1'b1};
      vecs[4] = '{1, 1'b1, 0, 7, 1'b0, 95, 2, 4'd0, 32'hFFFF_FF7F, 1'b0};

      for (int i = 0; i < 2; i++) begin
         fault_en[i]   = 1'b0;
         fault_addr[i] = 0;
         fault_bit[i]  = 0;
         fault_val[i]  = 1'b0;
      end

      rst      = 1'b1;
      start[0] = 1'b1;
      start[1] = 1'b1;
      repeat (3) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++)
            check_output("rst_hold", {busy[k], done[k], pass[k], fail[k], fail_addr[k], fail_data[k],
                                      err_cnt[k], mem_wren[k], mem_rden[k], mem_addr[k], mem_wr_data[k]}, '0);
      end
      rst      = 1'b0;
      start[0] = 1'b0;
      start[1] = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++)
         check_output("rst_idle", {busy[k], done[k], pass[k], fail[k], err_cnt[k], mem_wren[k], mem_rden[k]}, '0);

      for (int i = 0; i < 5; i++) begin
         s             = vecs[i].sel;
         fault_en[s]   = vecs[i].fen;
         fault_addr[s] = vecs[i].faddr;
         fault_bit[s]  = vecs[i].fbit;
         fault_val[s]  = vecs[i].fval;
         apply_stimulus(s, vecs[i].mid, 0, r_err, r_faddr, r_fdata, r_pass);
         check_output("tbl_err_cnt",   r_err,   vecs[i].exp_err);
         check_output("tbl_fail_addr", r_faddr, vecs[i].exp_faddr);
         check_output("tbl_fail_data", r_fdata, vecs[i].exp_fdata);
         check_output("tbl_pass",      r_pass,  vecs[i].exp_pass);
      end

      fault_en[0] = 1'b0;
      apply_stimulus(0, 0, 50, r_err, r_faddr, r_fdata, r_pass);
      apply_stimulus(0, 0, 0, r_err, r_faddr, r_fdata, r_pass);

      repeat (8) begin
         s             = int'($urandom_range(0, 1));
         fault_en[s]   = ($urandom_range(0, 3) != 0);
         fault_addr[s] = int'($urandom_range(0, DEPTH - 1));
         fault_bit[s]  = int'($urandom_range(0, 31));
         fault_val[s]  = 1'($urandom_range(0, 1));
         apply_stimulus(s, int'($urandom_range(0, N_OPS)), 0, r_err, r_faddr, r_fdata, r_pass);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
